// File: rtl/thumb_hw_fetch.sv
// -----------------------------------------------------------------------------
// thumb_hw_fetch
//
// Instruction-side fetch unit. Issues halfword reads into a single-cycle
// latency instruction memory, buffers the returned halfwords (with their
// addresses) in a small FIFO and presents them to the core with a
// valid/ready handshake. A one-cycle redirect pulse flushes the FIFO and
// restarts fetch at a new address; a read issued in the redirect cycle is
// marked to be dropped when it returns.
//
// Optional feature macro: THUMB_HW_FETCH_PERF_EN
//   Adds hw_count (accepted halfwords) and stall_cycles (cycles with the core
//   ready but no halfword available). Both are cleared only by rst.
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   fetch_limit     first halfword address that is not fetched
//   redirect_valid  one-cycle pulse: flush and restart at redirect_addr
//   redirect_addr   restart address (halfword units)
//   mem_rd_en       memory read strobe
//   mem_addr        halfword read address
//   mem_rdata       read data, valid the cycle after mem_rd_en
//   hw_valid        hw_data/hw_addr hold a valid halfword
//   hw_ready        core accepts the halfword
//   hw_data         halfword at the FIFO head
//   hw_addr         address of hw_data
//   done            fetch reached fetch_limit, FIFO empty, nothing in flight
//   hw_count        (perf) accepted halfwords
//   stall_cycles    (perf) cycles with hw_ready && !hw_valid
// -----------------------------------------------------------------------------
module thumb_hw_fetch #(
    parameter int ADDR_W = 21,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_limit,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              hw_valid,
    input  logic              hw_ready,
    output logic [15:0]       hw_data,
    output logic [ADDR_W-1:0] hw_addr,
    output logic              done
`ifdef THUMB_HW_FETCH_PERF_EN
    ,
    output logic [31:0]       hw_count,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] inflight_addr;
    logic              inflight;
    logic              drop;

    logic [15:0]       fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [CNT_W:0]    occupancy;
    logic              rd_issue;
    logic              push;
    logic              pop;

    // Entries already buffered plus the one on its way back: a read is only
    // issued when there is guaranteed room for its return.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight);
    assign rd_issue  = !rst && (fetch_addr < fetch_limit)
                       && (occupancy < (CNT_W+1)'(DEPTH));

    assign mem_rd_en = rd_issue;
    assign mem_addr  = rst ? '0 : fetch_addr;

    assign hw_valid  = !rst && (count != '0);
    assign hw_data   = hw_valid ? fifo_data[rd_ptr] : '0;
    assign hw_addr   = hw_valid ? fifo_addr[rd_ptr] : '0;
    assign done      = !rst && (fetch_addr >= fetch_limit)
                       && (count == '0) && !inflight;

    assign push = inflight && !drop;
    assign pop  = hw_valid && hw_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr    <= '0;
            inflight_addr <= '0;
            inflight      <= 1'b0;
            drop          <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            inflight <= rd_issue;
            if (rd_issue) begin
                inflight_addr <= fetch_addr;
            end
            if (redirect_valid) begin
                // Flush wins over a same-cycle push; a handshake in this cycle
                // has already been seen by the core and needs no bookkeeping.
                fetch_addr <= redirect_addr;
                drop       <= rd_issue;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
            end else begin
                if (rd_issue) begin
                    fetch_addr <= fetch_addr + ADDR_W'(1);
                end
                if (inflight && drop) begin
                    drop <= 1'b0;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; validity is tracked
    // by count alone, and outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_addr[wr_ptr] <= inflight_addr;
        end
    end

`ifdef THUMB_HW_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hw_count     <= '0;
            stall_cycles <= '0;
        end else begin
            if (pop) begin
                hw_count <= hw_count + 32'd1;
            end
            if (hw_ready && !hw_valid) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
